// File: rtl/writeback_unit.sv
// Writeback stage: registers ALU results or aligned/extended load data onto the register-file write port.
// Optional load-response timeout is compiled in with `define WB_LOAD_TIMEOUT_EN.
module writeback_unit #(
  parameter int XLEN           = 32,
  parameter int REG_ADDR_W     = 5,
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic                        in_is_load,
  input  logic [2:0]                  in_funct3,
  input  logic [$clog2(XLEN/8)-1:0]   in_addr_lo,
  input  logic [XLEN-1:0]             in_alu_result,
  input  logic [REG_ADDR_W-1:0]       in_rd,
  input  logic                        in_rd_we,
  input  logic                        mem_r_valid,
  input  logic [XLEN-1:0]             mem_r_data,
  output logic                        rf_we,
  output logic [REG_ADDR_W-1:0]       rf_waddr,
  output logic [XLEN-1:0]             rf_wdata,
  output logic                        busy,
  output logic                        load_err
);

  localparam int AW = $clog2(XLEN/8);

  if (!((XLEN == 32) || (XLEN == 64)) || (TIMEOUT_CYCLES < 1)) begin : g_bad_params
    $error("writeback_unit: XLEN must be 32 or 64 and TIMEOUT_CYCLES >= 1");
  end

  typedef enum logic [0:0] {
    IDLE     = 1'b0,
    WAIT_MEM = 1'b1
  } state_t;

  state_t                state_r;
  logic [REG_ADDR_W-1:0] rd_r;
  logic                  wq_r;
  logic [2:0]            funct3_r;
  logic [AW-1:0]         addr_lo_r;
  logic                  rf_we_r;
  logic [REG_ADDR_W-1:0] rf_waddr_r;
  logic [XLEN-1:0]       rf_wdata_r;
  logic                  wq_s;
  logic                  accept_s;
  logic [XLEN-1:0]       load_data_s;

  // Select the addressed byte/half/word from the raw response and extend it.
  // Halves ignore addr_lo[0]; the 64-bit word select is the top address bit.
  function automatic logic [XLEN-1:0] extract(
    input logic [XLEN-1:0] data,
    input logic [2:0]      f3,
    input logic [AW-1:0]   lo
  );
    logic [XLEN-1:0] res;
    res = data;
    case (f3)
      3'b000:  res = XLEN'($signed(8'(data >> {lo, 3'b000})));
      3'b001:  res = XLEN'($signed(16'(data >> {lo[AW-1:1], 4'b0000})));
      3'b100:  res = XLEN'(8'(data >> {lo, 3'b000}));
      3'b101:  res = XLEN'(16'(data >> {lo[AW-1:1], 4'b0000}));
      3'b010:  res = (XLEN == 64) ? XLEN'($signed(32'(data >> {lo[AW-1], 5'b00000}))) : data;
      3'b110:  res = (XLEN == 64) ? XLEN'(32'(data >> {lo[AW-1], 5'b00000})) : data;
      default: res = data;
    endcase
    return res;
  endfunction

  assign wq_s        = in_rd_we && (in_rd != {REG_ADDR_W{1'b0}});
  assign accept_s    = in_valid && in_ready;
  assign load_data_s = extract(mem_r_data, funct3_r, addr_lo_r);

  assign in_ready = (state_r == IDLE);
  assign busy     = (state_r == WAIT_MEM);
  assign rf_we    = rf_we_r;
  assign rf_waddr = rf_waddr_r;
  assign rf_wdata = rf_wdata_r;

`ifdef WB_LOAD_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] cnt_r;
  logic             load_err_r;

  assign load_err = load_err_r;

  // Handshake FSM, write port and load timeout counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= IDLE;
      rd_r       <= {REG_ADDR_W{1'b0}};
      wq_r       <= 1'b0;
      funct3_r   <= 3'b000;
      addr_lo_r  <= {AW{1'b0}};
      rf_we_r    <= 1'b0;
      rf_waddr_r <= {REG_ADDR_W{1'b0}};
      rf_wdata_r <= {XLEN{1'b0}};
      cnt_r      <= {CNT_W{1'b0}};
      load_err_r <= 1'b0;
    end else begin
      rf_we_r    <= 1'b0;
      load_err_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (accept_s && in_is_load) begin
            state_r   <= WAIT_MEM;
            rd_r      <= in_rd;
            wq_r      <= wq_s;
            funct3_r  <= in_funct3;
            addr_lo_r <= in_addr_lo;
            cnt_r     <= {CNT_W{1'b0}};
          end else if (accept_s) begin
            rf_we_r    <= wq_s;
            rf_waddr_r <= in_rd;
            rf_wdata_r <= in_alu_result;
          end else begin
            state_r <= IDLE;
          end
        end
        WAIT_MEM: begin
          // A response on the final waiting edge still takes priority over the timeout.
          if (mem_r_valid) begin
            state_r    <= IDLE;
            rf_we_r    <= wq_r;
            rf_waddr_r <= rd_r;
            rf_wdata_r <= load_data_s;
          end else if (cnt_r == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            state_r    <= IDLE;
            load_err_r <= 1'b1;
            cnt_r      <= {CNT_W{1'b0}};
          end else begin
            cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
          end
        end
        default: state_r <= IDLE;
      endcase
    end
  end
`else
  assign load_err = 1'b0;

  // Handshake FSM and write port; loads wait for their response indefinitely.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= IDLE;
      rd_r       <= {REG_ADDR_W{1'b0}};
      wq_r       <= 1'b0;
      funct3_r   <= 3'b000;
      addr_lo_r  <= {AW{1'b0}};
      rf_we_r    <= 1'b0;
      rf_waddr_r <= {REG_ADDR_W{1'b0}};
      rf_wdata_r <= {XLEN{1'b0}};
    end else begin
      rf_we_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (accept_s && in_is_load) begin
            state_r   <= WAIT_MEM;
            rd_r      <= in_rd;
            wq_r      <= wq_s;
            funct3_r  <= in_funct3;
            addr_lo_r <= in_addr_lo;
          end else if (accept_s) begin
            rf_we_r    <= wq_s;
            rf_waddr_r <= in_rd;
            rf_wdata_r <= in_alu_result;
          end else begin
            state_r <= IDLE;
          end
        end
        WAIT_MEM: begin
          if (mem_r_valid) begin
            state_r    <= IDLE;
            rf_we_r    <= wq_r;
            rf_waddr_r <= rd_r;
            rf_wdata_r <= load_data_s;
          end else begin
            state_r <= WAIT_MEM;
          end
        end
        default: state_r <= IDLE;
      endcase
    end
  end
`endif

endmodule

// File: tb/tb_writeback_unit.sv
// Directed self-checking bench for writeback_unit (XLEN=32); timeout tests build with WB_LOAD_TIMEOUT_EN.
module tb_writeback_unit;

`ifdef WB_LOAD_TIMEOUT_EN
  localparam int TO = 4;
`else
  localparam int TO = 15;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic        in_is_load;
  logic [2:0]  in_funct3;
  logic [1:0]  in_addr_lo;
  logic [31:0] in_alu_result;
  logic [4:0]  in_rd;
  logic        in_rd_we;
  logic        mem_r_valid;
  logic [31:0] mem_r_data;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        busy;
  logic        load_err;

  int vec_cnt = 0;
  int err_cnt = 0;

  writeback_unit #(.XLEN(32), .REG_ADDR_W(5), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_is_load(in_is_load), .in_funct3(in_funct3), .in_addr_lo(in_addr_lo),
    .in_alu_result(in_alu_result), .in_rd(in_rd), .in_rd_we(in_rd_we),
    .mem_r_valid(mem_r_valid), .mem_r_data(mem_r_data), .rf_we(rf_we),
    .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .busy(busy), .load_err(load_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; in_is_load = 1'b0; in_funct3 = 3'b000;
    in_addr_lo = 2'd0; in_alu_result = 32'h0; in_rd = 5'd0; in_rd_we = 1'b0;
    mem_r_valid = 1'b0; mem_r_data = 32'h0;
    tick(); tick();
    vec_cnt++;
    if ({rf_we, rf_waddr, rf_wdata, load_err, busy, in_ready} !== {1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 1'b1}) begin
      err_cnt++;
      $display("FAIL reset: we=%b waddr=%0d wdata=%h err=%b busy=%b rdy=%b, want 0/0/0/0/0/1",
               rf_we, rf_waddr, rf_wdata, load_err, busy, in_ready);
    end
    #2 rst_n = 1'b1;
    tick();
  endtask

  task automatic test_nonload();
    in_valid = 1'b1; in_is_load = 1'b0; in_rd = 5'd5; in_rd_we = 1'b1; in_alu_result = 32'h1234_5678;
    tick();
    in_valid = 1'b0;
    vec_cnt++;
    if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, 5'd5, 32'h1234_5678}) begin
      err_cnt++;
      $display("FAIL nonload_write: got we=%b waddr=%0d wdata=%h, want 1/5/12345678", rf_we, rf_waddr, rf_wdata);
    end
    tick();
    vec_cnt++;
    if (rf_we !== 1'b0) begin
      err_cnt++;
      $display("FAIL nonload_we_drop: got rf_we=%b, want 0", rf_we);
    end
  endtask

  task automatic test_x0();
    in_valid = 1'b1; in_is_load = 1'b0; in_rd = 5'd0; in_rd_we = 1'b1; in_alu_result = 32'hFFFF_FFFF;
    tick();
    in_valid = 1'b0;
    vec_cnt++;
    if ({rf_we, in_ready} !== 2'b01) begin
      err_cnt++;
      $display("FAIL x0_suppress: got rf_we=%b in_ready=%b, want 0/1", rf_we, in_ready);
    end
    in_valid = 1'b1; in_rd = 5'd6; in_rd_we = 1'b0; in_alu_result = 32'h5555_AAAA;
    tick();
    in_valid = 1'b0;
    vec_cnt++;
    if (rf_we !== 1'b0) begin
      err_cnt++;
      $display("FAIL rd_we0_suppress: got rf_we=%b, want 0", rf_we);
    end
  endtask

  // Load with a response after `wait_cyc` waiting cycles; junk non-load bundles are driven while waiting.
  task automatic test_load(input string name, input logic [2:0] f3, input logic [1:0] lo,
                           input logic [4:0] rd, input logic rd_we, input logic [31:0] data,
                           input int wait_cyc, input logic exp_we, input logic [31:0] exp_data);
    in_valid = 1'b1; in_is_load = 1'b1; in_funct3 = f3; in_addr_lo = lo;
    in_rd = rd; in_rd_we = rd_we; mem_r_valid = 1'b0;
    tick();
    in_is_load = 1'b0; in_rd = 5'd7; in_rd_we = 1'b1; in_funct3 = 3'b011; in_addr_lo = 2'd0;
    in_alu_result = 32'hBAD0_BAD0;
    for (int i = 0; i < wait_cyc; i++) begin
      vec_cnt++;
      if ({busy, in_ready, rf_we} !== 3'b100) begin
        err_cnt++;
        $display("FAIL %s_wait%0d: got busy=%b in_ready=%b rf_we=%b, want 1/0/0", name, i, busy, in_ready, rf_we);
      end
      tick();
    end
    mem_r_valid = 1'b1; mem_r_data = data;
    tick();
    mem_r_valid = 1'b0; in_valid = 1'b0;
    vec_cnt++;
    if ({rf_we, in_ready, busy} !== {exp_we, 1'b1, 1'b0} || (exp_we && {rf_waddr, rf_wdata} !== {rd, exp_data})) begin
      err_cnt++;
      $display("FAIL %s_result: got we=%b waddr=%0d wdata=%h rdy=%b, want we=%b waddr=%0d wdata=%h rdy=1",
               name, rf_we, rf_waddr, rf_wdata, in_ready, exp_we, rd, exp_data);
    end
    tick();
    vec_cnt++;
    if (rf_we !== 1'b0) begin
      err_cnt++;
      $display("FAIL %s_we_drop: got rf_we=%b, want 0", name, rf_we);
    end
  endtask

  task automatic test_mem_valid_idle();
    mem_r_valid = 1'b1; mem_r_data = 32'h1111_1111;
    tick();
    mem_r_valid = 1'b0;
    vec_cnt++;
    if ({rf_we, busy} !== 2'b00) begin
      err_cnt++;
      $display("FAIL idle_mem_valid: got rf_we=%b busy=%b, want 0/0", rf_we, busy);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_is_load = 1'b0; in_rd_we = 1'b1;
      in_rd = 5'(i + 1); in_alu_result = 32'hA000_0000 + 32'(i);
      tick();
      vec_cnt++;
      if ({rf_we, rf_waddr, rf_wdata, in_ready} !== {1'b1, 5'(i + 1), 32'hA000_0000 + 32'(i), 1'b1}) begin
        err_cnt++;
        $display("FAIL b2b_%0d: got we=%b waddr=%0d wdata=%h rdy=%b, want 1/%0d/%h/1",
                 i, rf_we, rf_waddr, rf_wdata, in_ready, i + 1, 32'hA000_0000 + 32'(i));
      end
    end
    in_valid = 1'b0;
    tick();
    vec_cnt++;
    if (rf_we !== 1'b0) begin
      err_cnt++;
      $display("FAIL b2b_drop: got rf_we=%b, want 0", rf_we);
    end
  endtask

  task automatic test_reset_mid_load();
    in_valid = 1'b1; in_is_load = 1'b1; in_funct3 = 3'b010; in_rd = 5'd9; in_rd_we = 1'b1;
    tick();
    in_valid = 1'b0; in_is_load = 1'b0;
    vec_cnt++;
    if (busy !== 1'b1) begin
      err_cnt++;
      $display("FAIL midload_busy: got busy=%b, want 1", busy);
    end
    rst_n = 1'b0;
    #1;
    vec_cnt++;
    if ({busy, in_ready, rf_we} !== 3'b010) begin
      err_cnt++;
      $display("FAIL midload_async_rst: got busy=%b rdy=%b we=%b, want 0/1/0", busy, in_ready, rf_we);
    end
    #2 rst_n = 1'b1;
    mem_r_valid = 1'b1; mem_r_data = 32'hCAFE_F00D;
    tick();
    mem_r_valid = 1'b0;
    vec_cnt++;
    if ({rf_we, in_ready, rf_wdata} !== {1'b0, 1'b1, 32'h0}) begin
      err_cnt++;
      $display("FAIL midload_no_write: got we=%b rdy=%b wdata=%h, want 0/1/00000000", rf_we, in_ready, rf_wdata);
    end
  endtask

`ifdef WB_LOAD_TIMEOUT_EN
  task automatic test_timeout(input logic respond);
    in_valid = 1'b1; in_is_load = 1'b1; in_funct3 = 3'b010; in_addr_lo = 2'd0; in_rd = 5'd12; in_rd_we = 1'b1;
    mem_r_valid = 1'b0;
    tick();
    in_valid = 1'b0; in_is_load = 1'b0;
    for (int i = 0; i < 3; i++) begin
      vec_cnt++;
      if ({busy, load_err} !== 2'b10) begin
        err_cnt++;
        $display("FAIL timeout_wait%0d: got busy=%b load_err=%b, want 1/0", i, busy, load_err);
      end
      tick();
    end
    mem_r_valid = respond; mem_r_data = 32'h0BAD_F00D;
    tick();
    mem_r_valid = 1'b0;
    vec_cnt++;
    if ({load_err, rf_we, in_ready} !== {~respond, respond, 1'b1} || (respond && rf_wdata !== 32'h0BAD_F00D)) begin
      err_cnt++;
      $display("FAIL timeout_edge(resp=%b): got err=%b we=%b rdy=%b wdata=%h, want err=%b we=%b rdy=1",
               respond, load_err, rf_we, in_ready, rf_wdata, ~respond, respond);
    end
    tick();
    vec_cnt++;
    if ({load_err, rf_we} !== 2'b00) begin
      err_cnt++;
      $display("FAIL timeout_pulse_end: got err=%b we=%b, want 0/0", load_err, rf_we);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_nonload();
    test_x0();
    test_load("lb",   3'b000, 2'd2, 5'd3, 1'b1, 32'h0080_0000, 3, 1'b1, 32'hFFFF_FF80);
    test_load("lbu",  3'b100, 2'd2, 5'd3, 1'b1, 32'h0080_0000, 3, 1'b1, 32'h0000_0080);
    test_load("lb3",  3'b000, 2'd3, 5'd4, 1'b1, 32'h7F00_0000, 0, 1'b1, 32'h0000_007F);
    test_load("lh",   3'b001, 2'd2, 5'd3, 1'b1, 32'h8001_0000, 1, 1'b1, 32'hFFFF_8001);
    test_load("lhu",  3'b101, 2'd2, 5'd3, 1'b1, 32'h8001_0000, 1, 1'b1, 32'h0000_8001);
    test_load("lh3",  3'b001, 2'd3, 5'd8, 1'b1, 32'h8001_0000, 2, 1'b1, 32'hFFFF_8001);
    test_load("lh0",  3'b001, 2'd0, 5'd8, 1'b1, 32'h8001_7FFE, 0, 1'b1, 32'h0000_7FFE);
    test_load("lw",   3'b010, 2'd0, 5'd31, 1'b1, 32'hDEAD_BEEF, 2, 1'b1, 32'hDEAD_BEEF);
    test_load("lwu",  3'b110, 2'd0, 5'd10, 1'b1, 32'h8765_4321, 1, 1'b1, 32'h8765_4321);
    test_load("f111", 3'b111, 2'd1, 5'd11, 1'b1, 32'hF0F0_0F0F, 0, 1'b1, 32'hF0F0_0F0F);
    test_load("ld_x0", 3'b010, 2'd0, 5'd0, 1'b1, 32'h1357_9BDF, 2, 1'b0, 32'h0);
    test_mem_valid_idle();
    test_back_to_back();
    test_reset_mid_load();
`ifdef WB_LOAD_TIMEOUT_EN
    test_timeout(1'b0);
    test_timeout(1'b1);
`else
    vec_cnt++;
    if (load_err !== 1'b0) begin
      err_cnt++;
      $display("FAIL load_err_tied: got %b, want 0", load_err);
    end
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/writeback_unit.md
Name: writeback_unit

Overview:
Parametrised writeback stage sitting between the memory-access stage and the register file. It accepts one retiring instruction per handshake and registers the ALU result or the load data. For loads it waits for a possibly delayed memory response, then aligns and sign- or zero-extends the data per funct3. It drives a registered register-file write port and suppresses writes to x0.

Parameters:
XLEN, 32, datapath width; legal values 32 or 64.
REG_ADDR_W, 5, register index width.
TIMEOUT_CYCLES, 15, number of WAIT_MEM cycles before the load is abandoned; used only with the optional feature; must be >= 1.

Ports:
clk  in  1  clock; all state updates on the rising edge.
rst_n  in  1  asynchronous active-low reset.
in_valid  in  1  instruction bundle valid.
in_ready  out  1  unit can accept a bundle; equals (state==IDLE).
in_is_load  in  1  bundle is a load.
in_funct3  in  3  load size/sign encoding.
in_addr_lo  in  log2(XLEN/8)  low bits of the load address.
in_alu_result  in  XLEN  result for non-loads.
in_rd  in  REG_ADDR_W  destination register.
in_rd_we  in  1  instruction writes rd.
mem_r_valid  in  1  load response valid.
mem_r_data  in  XLEN  raw aligned-word response.
rf_we  out  1  register-file write strobe, registered.
rf_waddr  out  REG_ADDR_W  write address, registered.
rf_wdata  out  XLEN  write data, registered.
busy  out  1  state==WAIT_MEM.
load_err  out  1  one-cycle pulse on load timeout; tied 0 without the feature.

Behaviour:
- Reset, asynchronous: state=IDLE, rf_we=0, rf_waddr=0, rf_wdata=0, load_err=0, timeout counter=0. A reset asserted during WAIT_MEM abandons the load and performs no write.
- The bundle is accepted on a rising edge with in_valid && in_ready. The unit latches rd, rd_we, funct3, addr_lo and is_load.
- Write qualifier: wq = in_rd_we && (in_rd != 0).
- IDLE, non-load accepted at edge N:
  - In cycle N+1: rf_we=wq, rf_waddr=in_rd, rf_wdata=in_alu_result.
  - State stays IDLE, so back-to-back non-loads run at full throughput.
- IDLE, load accepted: state goes to WAIT_MEM, and rf_we=0 on the next cycle.
- WAIT_MEM:
  - in_ready=0; in_valid is ignored.
  - On an edge with mem_r_valid=1: rf_we=latched wq, rf_waddr=latched rd, rf_wdata=extract(mem_r_data); state goes to IDLE.
  - Otherwise rf_we=0.
  - The response is consumed even when wq=0.
- mem_r_valid is ignored in IDLE. rf_we is 0 on every cycle that has no write event, so it is never held.
- Extraction (sh = 8*addr_lo for bytes; halves are selected by addr_lo[msb:1], with addr_lo[0] ignored):
  - 000 LB: sign-extend byte.
  - 001 LH: sign-extend half.
  - 100 LBU: zero-extend byte.
  - 101 LHU: zero-extend half.
  - 010 LW: XLEN=32 full word; XLEN=64 word selected by addr_lo[2], sign-extended.
  - 110 LWU: XLEN=64 zero-extended word; XLEN=32 full word.
  - 011, 111: full XLEN word.
- Latency: non-load is 1 cycle after acceptance. Load is 1 cycle after the mem_r_valid edge.

Optional Feature:
Macro WB_LOAD_TIMEOUT_EN.
- Defined:
  - The counter clears on entry to WAIT_MEM and increments each WAIT_MEM cycle without mem_r_valid.
  - When it reaches TIMEOUT_CYCLES: state goes to IDLE, no write, load_err=1 for exactly one cycle.
  - If mem_r_valid arrives on the timeout edge, the response wins: normal write, load_err=0.
- Undefined: WAIT_MEM waits indefinitely; load_err is constant 0; no counter logic.

Test Plan:
- Reset then non-load: rd=5, rd_we=1, alu=0x1234_5678 -> next cycle rf_we=1, waddr=5, wdata=0x12345678; following cycle rf_we=0.
- x0 suppression: non-load rd=0, rd_we=1, alu=0xFFFF_FFFF -> rf_we stays 0; in_ready stays 1.
- LB: addr_lo=2, mem_r_data=0x0080_0000, rd=3, mem_r_valid 3 cycles later -> in_ready=0 and busy=1 for 3 cycles, then rf_wdata=0xFFFF_FF80, rf_we=1. Same with LBU -> 0x0000_0080.
- LH/LHU: addr_lo=2, mem_r_data=0x8001_0000 -> LH 0xFFFF_8001, LHU 0x0000_8001. Back-to-back non-loads on 4 consecutive cycles -> 4 consecutive rf_we pulses with matching data.
- Reset mid-load: accept load, assert rst_n=0 in WAIT_MEM, release, then drive mem_r_valid=1 -> no rf_we, state IDLE, in_ready=1.
- WB_LOAD_TIMEOUT_EN, TIMEOUT_CYCLES=4: load with no response -> load_err pulses once after 4 WAIT_MEM cycles, rf_we=0, in_ready returns to 1. Response on the 4th cycle -> write occurs, load_err=0.
